// File: rtl/rmi_sched_reader_pkg.sv
// rmi_sched_reader_pkg: shared state encoding, bank constants and default widths for the RMI schedule reader and writer
package rmi_pkg;
    localparam int RMI_ADDR_W = 32;
    localparam int RMI_DATA_W = 32;
    localparam logic BANK1 = 1'b1;
    localparam logic BANK2 = 1'b0;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;
endpackage

// File: rtl/rmi_sched_reader_if.sv
// rmi_sched_reader_if: bank-select/start control, both BRAM read ports and the schedule stream of the reader
interface rmi_sched_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              selMem;
    logic              start;
    logic              rdEn1;
    logic [ADDR_W-1:0] rdAdd1;
    logic [DATA_W-1:0] rdData1;
    logic              rdEn2;
    logic [ADDR_W-1:0] rdAdd2;
    logic [DATA_W-1:0] rdData2;
    logic              schedValid;
    logic              schedReady;
    logic [DATA_W-1:0] schedData;
    logic [ADDR_W-1:0] schedIdx;
    logic              busy;
    logic              done;
    logic              bankActive;
    modport master (
        input  selMem, start, rdData1, rdData2, schedReady,
        output rdEn1, rdAdd1, rdEn2, rdAdd2, schedValid, schedData, schedIdx, busy, done, bankActive
    );
    modport slave (
        output selMem, start, rdData1, rdData2, schedReady,
        input  rdEn1, rdAdd1, rdEn2, rdAdd2, schedValid, schedData, schedIdx, busy, done, bankActive
    );
endinterface

// File: rtl/rmi_sched_reader_skid_fifo.sv
// rmi_skid_fifo: 2-entry FIFO that absorbs BRAM read latency behind the schedule stream
module rmi_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic [1:0]        count_o
);
    logic [DATA_W-1:0] mem_q [2];
    logic              wr_q;
    logic              rd_q;
    logic [1:0]        cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    // storage and pointers; callers never push when full nor pop when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) mem_q[wr_q] <= din_i;
            wr_q  <= wr_q ^ push_i;
            rd_q  <= rd_q ^ pop_i;
            cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
        end
    end
endmodule

// File: rtl/rmi_sched_reader.sv
// rmi_sched_reader: streams one schedule pass from the active BRAM; RMI_SCHED_LOOP_EN makes passes repeat back-to-back
module rmi_sched_reader
    import rmi_pkg::*;
#(
    parameter int ADDR_W    = RMI_ADDR_W,
    parameter int DATA_W    = RMI_DATA_W,
    parameter int SCHED_LEN = 6
) (
    input logic          clk,
    input logic          rst,
    rmi_sched_if.master  bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SCHED_LEN - 1);
    state_t            st_q;
    logic [ADDR_W-1:0] issued_q;
    logic [ADDR_W-1:0] idx_q;
    logic              bank_q;
    logic              rd_vld_q;
    logic              rd_bank_q;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] head;
    logic              pop;
    logic              issue;
    logic              last_iss;
    logic              last_pop;
    logic              rd_en1;
    logic              rd_en2;
    // a read may issue only if its word is sure to find a free slot, counting the slot freed by this cycle's pop
    assign pop      = (cnt != 2'd0) && bus.schedReady;
    assign issue    = (st_q == ST_READ) && (({1'b0, cnt} + {2'b0, rd_vld_q}) < (3'd2 + {2'b0, pop}));
    assign last_iss = issued_q == LAST;
    assign last_pop = pop && (idx_q == LAST);
    assign rd_en1   = issue && (bank_q == BANK1);
    assign rd_en2   = issue && (bank_q == BANK2);
    assign bus.rdEn1      = rd_en1;
    assign bus.rdAdd1     = rd_en1 ? issued_q : '0;
    assign bus.rdEn2      = rd_en2;
    assign bus.rdAdd2     = rd_en2 ? issued_q : '0;
    assign bus.schedValid = cnt != 2'd0;
    assign bus.schedData  = head;
    assign bus.schedIdx   = idx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.bankActive = bank_q;
    rmi_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rd_vld_q),
        .pop_i   (pop),
        .din_i   (rd_bank_q == BANK1 ? bus.rdData1 : bus.rdData2),
        .dout_o  (head),
        .count_o (cnt)
    );
    // pass sequencing: bank latch, read issue counter, output index and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= ST_IDLE;
            issued_q  <= '0;
            idx_q     <= '0;
            bank_q    <= BANK1;
            rd_vld_q  <= 1'b0;
            rd_bank_q <= BANK1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_vld_q  <= issue;
            rd_bank_q <= bank_q;
            done_q    <= last_pop;
            if (pop) idx_q <= last_pop ? '0 : idx_q + ADDR_W'(1);
            case (st_q)
                ST_IDLE: if (bus.start && !done_q) begin
                    bank_q   <= bus.selMem;
                    issued_q <= '0;
                    idx_q    <= '0;
                    busy_q   <= 1'b1;
                    st_q     <= ST_READ;
                end
                ST_READ: if (issue) begin
`ifdef RMI_SCHED_LOOP_EN
                    issued_q <= last_iss ? '0 : issued_q + ADDR_W'(1);
                    if (last_iss) bank_q <= bus.selMem;
`else
                    issued_q <= issued_q + ADDR_W'(1);
                    if (last_iss) st_q <= ST_DRAIN;
`endif
                end
                ST_DRAIN: if (last_pop) begin
                    st_q   <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rmi_sched_reader.sv
// tb_rmi_sched_reader: randomized passes against a word-list model of the schedule stream (LEN 6 and LEN 1 instances)
module tb_rmi_sched_reader;
    localparam int AW = 32;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel_mem = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic use1 = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [DW-1:0] mem1 [64];
    logic [DW-1:0] mem2 [64];
    always #5 clk = ~clk;
    rmi_sched_if #(.ADDR_W(AW), .DATA_W(DW)) s6 ();
    rmi_sched_if #(.ADDR_W(AW), .DATA_W(DW)) s1 ();
    rmi_sched_reader #(.ADDR_W(AW), .DATA_W(DW), .SCHED_LEN(6)) u6 (.clk(clk), .rst(rst), .bus(s6.master));
    rmi_sched_reader #(.ADDR_W(AW), .DATA_W(DW), .SCHED_LEN(1)) u1 (.clk(clk), .rst(rst), .bus(s1.master));
    assign s6.selMem     = sel_mem;
    assign s1.selMem     = sel_mem;
    assign s6.start      = start && !use1;
    assign s1.start      = start && use1;
    assign s6.schedReady = ready;
    assign s1.schedReady = ready;
    always @(posedge clk) begin
        if (s6.rdEn1) s6.rdData1 <= mem1[s6.rdAdd1[5:0]];
        if (s6.rdEn2) s6.rdData2 <= mem2[s6.rdAdd2[5:0]];
        if (s1.rdEn1) s1.rdData1 <= mem1[s1.rdAdd1[5:0]];
        if (s1.rdEn2) s1.rdData2 <= mem2[s1.rdAdd2[5:0]];
    end
    logic          o_valid, o_busy, o_done, o_bank, o_en1, o_en2;
    logic [DW-1:0] o_data;
    logic [AW-1:0] o_idx, o_add1, o_add2;
    assign o_valid = use1 ? s1.schedValid : s6.schedValid;
    assign o_busy  = use1 ? s1.busy : s6.busy;
    assign o_done  = use1 ? s1.done : s6.done;
    assign o_bank  = use1 ? s1.bankActive : s6.bankActive;
    assign o_en1   = use1 ? s1.rdEn1 : s6.rdEn1;
    assign o_en2   = use1 ? s1.rdEn2 : s6.rdEn2;
    assign o_data  = use1 ? s1.schedData : s6.schedData;
    assign o_idx   = use1 ? s1.schedIdx : s6.schedIdx;
    assign o_add1  = use1 ? s1.rdAdd1 : s6.rdAdd1;
    assign o_add2  = use1 ? s1.rdAdd2 : s6.rdAdd2;
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic check_reset_outputs();
        check("rst_en1", o_en1, 0);
        check("rst_en2", o_en2, 0);
        check("rst_add1", o_add1, 0);
        check("rst_add2", o_add2, 0);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_idx", o_idx, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_bank", o_bank, 1);
    endtask
    task automatic randomize_mems();
        for (int i = 0; i < 64; i++) begin
            mem1[i] = $urandom;
            mem2[i] = $urandom;
        end
    endtask
    task automatic run_pass(input logic bank, input int mode, input bit inj_start, input bit abort);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] p_data;
        logic [AW-1:0] p_idx;
        logic stall;
        int n, k, cyc, dn, last_c, first_c;
        n = use1 ? 1 : 6;
        for (int i = 0; i < n; i++) exp_q.push_back(bank ? mem1[i] : mem2[i]);
        k = 0; cyc = 0; dn = 0; last_c = -10; first_c = -1; stall = 1'b0;
        p_data = '0; p_idx = '0;
        @(posedge clk); #1 sel_mem = bank; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (cyc < 200 && !(dn > 0 && k == n)) begin
            ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
            if (k >= 2 && n > 2) sel_mem = ~bank;
            start = inj_start && (k == 3);
            if (abort && k == 4) begin
                rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0; start = 1'b0;
                @(negedge clk);
                check_reset_outputs();
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("abort_no_done", o_done, 0);
                    check("abort_no_valid", o_valid, 0);
                end
                return;
            end
            @(negedge clk);
            check("both_en", o_en1 && o_en2, 0);
            check("other_bank_en", bank ? o_en2 : o_en1, 0);
            check("other_bank_add", bank ? o_add2 : o_add1, 0);
            if (stall) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", o_data, p_data);
                check("hold_idx", o_idx, p_idx);
            end
            if (o_valid && first_c < 0) first_c = cyc;
            if (o_valid && ready) begin
                check("data", o_data, (k < n) ? exp_q[k] : '0);
                check("idx", o_idx, k);
                k++;
                last_c = cyc;
            end
            if (o_done) begin
                dn++;
                check("done_time", cyc, last_c + 1);
                check("done_words", k, n);
            end
            check("busy", o_busy, !o_done);
            stall = o_valid && !ready;
            p_data = o_data;
            p_idx = o_idx;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("words", k, n);
        check("done_count", dn, 1);
        check("bank_active", o_bank, bank);
        if (mode == 0) begin
            check("first_latency", first_c, 2);
            check("last_latency", last_c, n + 1);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("post_done", o_done, 0);
            check("post_busy", o_busy, 0);
            check("post_valid", o_valid, 0);
        end
    endtask
    task automatic run_loop();
        logic [DW-1:0] exp_q[$];
        int k, cyc, dn, last_c;
        randomize_mems();
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 6; i++) exp_q.push_back((p % 2 == 0) ? mem1[i] : mem2[i]);
        k = 0; cyc = 0; dn = 0; last_c = -10;
        ready = 1'b1;
        @(posedge clk); #1 sel_mem = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (cyc < 200 && !(dn >= 4 && k >= 24)) begin
            @(negedge clk);
            check("loop_both_en", o_en1 && o_en2, 0);
            check("loop_busy", o_busy, 1);
            if (o_done) begin
                dn++;
                check("loop_done_time", cyc, last_c + 1);
                check("loop_done_words", k, 6 * dn);
            end
            if (o_valid && k < 24) begin
                check("loop_data", o_data, exp_q[k]);
                check("loop_idx", o_idx, k % 6);
                check("loop_no_gap", cyc, k + 2);
                if (k % 6 == 0) begin
                    @(posedge clk); #1 sel_mem = ((k / 6 + 1) % 2 == 0);
                    k++;
                    last_c = cyc;
                    cyc++;
                    continue;
                end
                k++;
                last_c = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("loop_words", k, 24);
        check("loop_dones", dn, 4);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
    endtask
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
    initial begin
        for (int i = 0; i < 64; i++) begin
            mem1[i] = 32'hA0 + i;
            mem2[i] = 32'hB0 + i;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1 rst = 1'b0;
`ifdef RMI_SCHED_LOOP_EN
        run_loop();
`else
        run_pass(1'b1, 0, 1'b0, 1'b0);
        run_pass(1'b0, 0, 1'b0, 1'b0);
        run_pass(1'b1, 0, 1'b0, 1'b0);
        run_pass(1'b1, 1, 1'b0, 1'b0);
        run_pass(1'b0, 1, 1'b0, 1'b0);
        run_pass(1'b0, 2, 1'b1, 1'b1);
        run_pass(1'b0, 2, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            randomize_mems();
            run_pass(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
        end
        use1 = 1'b1;
        run_pass(1'b1, 0, 1'b0, 1'b0);
        run_pass(1'b0, 2, 1'b0, 1'b0);
        randomize_mems();
        run_pass(1'b1, 1, 1'b1, 1'b0);
        use1 = 1'b0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rmi_sched_reader.md
Name: rmi_sched_reader

Overview:
- Read-side counterpart of the RMI ping-pong schedule writer.
- Streams one full schedule pass (SCHED_LEN words) out of whichever BRAM `selMem` marks as active, then signals completion.
- Sits between the two schedule BRAMs' read ports and the schedule consumer.
- Uses a valid/ready output with backpressure, which absorbs the 1-cycle BRAM read latency.

Parameters:
- ADDR_W, 32, BRAM address width
- DATA_W, 32, schedule word width
- SCHED_LEN, 6, words per schedule pass; legal range 1..2^ADDR_W-1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset (see Behaviour)
- selMem  in  1  active bank from writer: 1 = BRAM1, 0 = BRAM2
- start  in  1  request one schedule pass
- rdEn1  out  1  BRAM1 read enable
- rdAdd1  out  ADDR_W  BRAM1 read address
- rdData1  in  DATA_W  BRAM1 read data, valid 1 cycle after rdEn1
- rdEn2  out  1  BRAM2 read enable
- rdAdd2  out  ADDR_W  BRAM2 read address
- rdData2  in  DATA_W  BRAM2 read data, valid 1 cycle after rdEn2
- schedValid  out  1  schedData valid
- schedReady  in  1  consumer accepts word
- schedData  out  DATA_W  schedule word
- schedIdx  out  ADDR_W  index of schedData within pass
- busy  out  1  pass in progress
- done  out  1  1-cycle pulse, pass complete
- bankActive  out  1  bank latched for current or last pass

Behaviour:
- Clocking and reset:
  - Single clock `clk`.
  - Reset `rst` is synchronous and active-high.
  - All logic is on posedge clk; no negedge logic.
- Reset values:
  - rdEn1/2 = 0, rdAdd1/2 = 0
  - schedValid = 0, schedData = 0, schedIdx = 0
  - busy = 0, done = 0, bankActive = 1
  - FIFO empty, issue and accept counters = 0
- Reset mid-pass: aborts immediately. In-flight BRAM data is discarded, no done pulse, state goes to IDLE.
- State IDLE:
  - busy = 0.
  - When start = 1: latch bankActive <= selMem, clear counters, go to READ. busy = 1 from the next cycle.
- State READ:
  - Issue a read to the latched bank when issued < SCHED_LEN and (fifoCount + inflight) < 2.
  - On issue: rdEn of that bank = 1, rdAdd = issued, issued increments.
  - The unlatched bank keeps rdEn = 0 and its address at 0.
  - When issued == SCHED_LEN, go to DRAIN.
- State DRAIN:
  - Wait until the FIFO is empty and nothing is in flight.
  - Then pulse done = 1 for exactly one cycle and go to IDLE.
- Capture and output:
  - The cycle after a read issue, rdData of the latched bank is pushed into a 2-entry FIFO.
  - The FIFO cannot overflow because of the credit rule above.
  - schedValid = FIFO non-empty; schedData = FIFO head.
  - A transfer occurs when schedValid && schedReady; schedIdx then increments, and wraps to 0 at pass start.
  - While schedValid = 1, schedData and schedIdx stay stable until accepted.
- Throughput: with schedReady held at 1, one word per cycle.
  - First schedValid appears 2 cycles after start is sampled.
  - done follows the cycle after the last transfer.
- Bank swap: selMem changes during a pass are ignored; the bank is only sampled when a pass starts.
- start while busy: ignored (not queued).
- done and start together: start is accepted in that same IDLE-return cycle only under the optional feature; otherwise start is honoured from the next IDLE cycle.
- Both-banks invariant: rdEn1 and rdEn2 are never 1 in the same cycle.

Optional Feature:
- Macro: RMI_SCHED_LOOP_EN.
- Defined:
  - After the last word, the block re-samples selMem and restarts immediately at address 0 with no IDLE gap.
  - done still pulses once per pass; busy stays 1 continuously.
  - start is needed only for the first pass; rst stops looping.
- Undefined: single pass per start, as described above.

Decomposition:
- Package rmi_pkg holds:
  - state encoding (ST_IDLE, ST_READ, ST_DRAIN)
  - bank constants BANK1 = 1'b1, BANK2 = 1'b0
  - default widths ADDR_W/DATA_W, shared with the writer
- One sub-module, rmi_skid_fifo: 2-entry FIFO with push/pop/count, parameterised on DATA_W.

Test Plan:
- Basic pass, BRAM1: selMem = 1, BRAM1 preloaded 0xA0..0xA5, start pulse, schedReady = 1 -> six words 0xA0..0xA5 with schedIdx 0..5 on consecutive cycles, rdEn2 never 1, one done pulse, bankActive = 1.
- Bank 2 with a swap mid-pass: selMem = 0, BRAM2 = 0xB0..0xB5, start, then selMem toggles to 1 at word 2 -> all six words from BRAM2, then a new start reads BRAM1.
- Backpressure: schedReady toggles 1,0,0,1 pattern -> no word lost or duplicated, schedData stable while valid && !ready, FIFO never exceeds 2, order 0..5 preserved.
- start while busy and reset mid-pass: second start at word 3 ignored; rst at word 4 -> next cycle all outputs at reset values, no done pulse; fresh start then yields a full 0..5 pass.
- SCHED_LEN = 1: a single word, done pulses the cycle after acceptance.
- Loop mode (RMI_SCHED_LOOP_EN): selMem flipped between passes -> passes alternate BRAM1/BRAM2 contents back-to-back with no gap cycle, and one done per pass.
